// File: rtl/ks_seq_mul.sv
// Sequential GF(2) Karatsuba multiplier: one shared H x H carry-less core, three passes.
// Optional modular reduction by x^W + POLY is enabled with macro KS_MODRED_EN.
module ks_seq_mul #(
    parameter int unsigned    W    = 116,
    parameter logic [W-1:0]   POLY = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-2:0]    d
`ifdef KS_MODRED_EN
    ,
    output logic [W-1:0]      r
`endif
);

    localparam int unsigned H  = W / 2;
    localparam int unsigned MW = 2 * H - 1;
    localparam int unsigned DW = 2 * W - 1;

    typedef enum logic [2:0] {
        IDLE,
        MUL_LO,
        MUL_HI,
        MUL_MID,
        COMB,
`ifdef KS_MODRED_EN
        REDUCE,
`endif
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [MW-1:0]   m1_q, m1_d;
    logic [MW-1:0]   m2_q, m2_d;
    logic [MW-1:0]   m3_q, m3_d;
    logic [DW-1:0]   d_q, d_d;
`ifdef KS_MODRED_EN
    logic [W-1:0]    r_q, r_d;
`endif

    logic [H-1:0]    mul_x, mul_y;
    logic [MW-1:0]   mul_p;
    logic [MW-1:0]   mid;
    logic [DW-1:0]   comb_val;

    // Long division of v by x^W + POLY, folding the top bit down one position at a time.
    function automatic logic [W-1:0] fold_mod(input logic [DW-1:0] v);
        logic [DW-1:0] t;
        t = v;
        for (int unsigned i = DW - 1; i >= W; i--) begin
            if (t[i]) begin
                t = t ^ (DW'(1) << i) ^ (DW'(POLY) << (i - W));
            end
        end
        return t[W-1:0];
    endfunction

    // Shared carry-less core; the state selects which half-operand pair it sees.
    always_comb begin
        mul_x = a_q[H-1:0];
        mul_y = b_q[H-1:0];
        case (state_q)
            MUL_HI: begin
                mul_x = a_q[W-1:H];
                mul_y = b_q[W-1:H];
            end
            MUL_MID: begin
                mul_x = a_q[W-1:H] ^ a_q[H-1:0];
                mul_y = b_q[W-1:H] ^ b_q[H-1:0];
            end
            default: ;
        endcase
        mul_p = '0;
        for (int unsigned i = 0; i < H; i++) begin
            if (mul_x[i]) begin
                mul_p = mul_p ^ (MW'(mul_y) << i);
            end
        end
    end

    always_comb begin
        mid      = m1_q ^ m2_q ^ m3_q;
        comb_val = DW'(m2_q) ^ (DW'(mid) << H) ^ (DW'(m1_q) << W);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m1_d    = m1_q;
        m2_d    = m2_q;
        m3_d    = m3_q;
        d_d     = d_q;
`ifdef KS_MODRED_EN
        r_d     = r_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = MUL_LO;
                end
            end
            MUL_LO: begin
                m2_d    = mul_p;
                state_d = MUL_HI;
            end
            MUL_HI: begin
                m1_d    = mul_p;
                state_d = MUL_MID;
            end
            MUL_MID: begin
                m3_d    = mul_p;
                state_d = COMB;
            end
            COMB: begin
                d_d     = comb_val;
`ifdef KS_MODRED_EN
                state_d = REDUCE;
`else
                state_d = DONE;
`endif
            end
`ifdef KS_MODRED_EN
            REDUCE: begin
                r_d     = fold_mod(d_q);
                state_d = DONE;
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m1_q    <= '0;
            m2_q    <= '0;
            m3_q    <= '0;
            d_q     <= '0;
`ifdef KS_MODRED_EN
            r_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m1_q    <= m1_d;
            m2_q    <= m2_d;
            m3_q    <= m3_d;
            d_q     <= d_d;
`ifdef KS_MODRED_EN
            r_q     <= r_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE) && rst_n;
    assign d         = d_q;
`ifdef KS_MODRED_EN
    assign r         = r_q;
`endif

endmodule
